// File: rtl/aes_stream_frontend_if.sv
// Beat input bus and block output bus between the stream source,
// the AES front end and the AES core.
interface aes_stream_frontend_if #(
   parameter int BUS_W = 32
);
   logic [BUS_W-1:0] in_data;
   logic [1:0]       in_cmd;
   logic [1:0]       key_len;
   logic             in_valid;
   logic             in_ready;
   logic [127:0]     core_blk;
   logic             core_dec;
   logic             core_valid;
   logic             core_ready;

   modport master (
      output in_data, in_cmd, key_len, in_valid,
      input  in_ready,
      input  core_blk, core_dec, core_valid,
      output core_ready
   );

   modport slave (
      input  in_data, in_cmd, key_len, in_valid,
      output in_ready,
      output core_blk, core_dec, core_valid,
      input  core_ready
   );
endinterface

// File: rtl/aes_stream_frontend.sv
// AES input front end: packs narrow beats into blocks and keys,
// queues tagged blocks and installs keys between blocks.
module aes_stream_frontend #(
   parameter int BUS_W      = 32,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        reset,
   aes_stream_frontend_if.slave        bus,
   output logic [255:0]                core_key,
   output logic [1:0]                  core_key_len,
   output logic                        key_valid,
   output logic                        key_loaded,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        err_cmd
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [3:0] BLK_LAST = 4'(128 / BUS_W - 1);

   typedef enum logic [1:0] {
      IDLE,
      ASM_BLK,
      ASM_KEY
   } st_t;

   function automatic logic [3:0] key_last(input logic [1:0] kl);
      case (kl)
         2'b00:   key_last = 4'((128 + BUS_W - 1) / BUS_W - 1);
         2'b01:   key_last = 4'((192 + BUS_W - 1) / BUS_W - 1);
         default: key_last = 4'((256 + BUS_W - 1) / BUS_W - 1);
      endcase
   endfunction

   st_t          st, st_n;
   logic [3:0]   cnt, cnt_n, idx;
   logic [1:0]   cmd_r, cmd_n;
   logic [1:0]   klen_r, klen_n;
   logic [127:0] bsh, bsh_n;
   logic [255:0] ksh, ksh_n, kmask;
   logic         push, pop, install, set_err, clr;
   logic         is_clr, is_key, is_data, full, acc, head_v;

   logic [255:0] key_q;
   logic [1:0]   klen_q;
   logic         kv_q, kl_q, err_q;

   logic [128:0]  mem [FIFO_DEPTH];
   logic [128:0]  head;
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [CW-1:0] occ;

   assign is_clr  = bus.in_cmd == 2'b11;
   assign is_key  = bus.in_cmd == 2'b10;
   assign is_data = !bus.in_cmd[1];
   assign full    = occ == CW'(FIFO_DEPTH);

   // Clear bypasses every stall so a wedged source can always recover.
   assign bus.in_ready = !reset && (is_clr ||
      !(kv_q || (is_data && full) ||
        (is_key && st == IDLE && occ != '0)));
   assign acc = bus.in_valid && bus.in_ready;

   always_comb begin
      st_n    = st;
      cnt_n   = cnt;
      cmd_n   = cmd_r;
      klen_n  = klen_r;
      bsh_n   = bsh;
      ksh_n   = ksh;
      idx     = cnt;
      push    = 1'b0;
      install = 1'b0;
      set_err = 1'b0;
      clr     = 1'b0;
      if (acc) begin
         unique case (1'b1)
            is_clr: begin
               clr   = 1'b1;
               st_n  = IDLE;
               cnt_n = '0;
            end
            is_data: begin
               if (st != ASM_BLK || bus.in_cmd != cmd_r) begin
                  idx     = '0;
                  set_err = st != IDLE;
               end
               if (!kl_q) begin
                  set_err = 1'b1;
                  st_n    = IDLE;
                  cnt_n   = '0;
               end else begin
                  bsh_n[7'(idx) * 7'(BUS_W) +: BUS_W] = bus.in_data;
                  cmd_n = bus.in_cmd;
                  if (idx == BLK_LAST) begin
                     push  = 1'b1;
                     st_n  = IDLE;
                     cnt_n = '0;
                  end else begin
                     st_n  = ASM_BLK;
                     cnt_n = idx + 4'd1;
                  end
               end
            end
            is_key: begin
               if (st != ASM_KEY) begin
                  idx     = '0;
                  klen_n  = bus.key_len;
                  set_err = st != IDLE;
               end
               if (klen_n == 2'b11) begin
                  set_err = 1'b1;
                  st_n    = IDLE;
                  cnt_n   = '0;
               end else begin
                  ksh_n[8'(idx) * 8'(BUS_W) +: BUS_W] = bus.in_data;
                  if (idx == key_last(klen_n)) begin
                     install = 1'b1;
                     st_n    = IDLE;
                     cnt_n   = '0;
                  end else begin
                     st_n  = ASM_KEY;
                     cnt_n = idx + 4'd1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      case (klen_n)
         2'b00:   kmask = {128'd0, ksh_n[127:0]};
         2'b01:   kmask = {64'd0, ksh_n[191:0]};
         default: kmask = ksh_n;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st     <= IDLE;
         cnt    <= '0;
         cmd_r  <= '0;
         klen_r <= '0;
         bsh    <= '0;
         ksh    <= '0;
      end else begin
         st     <= st_n;
         cnt    <= cnt_n;
         cmd_r  <= cmd_n;
         klen_r <= klen_n;
         bsh    <= bsh_n;
         ksh    <= ksh_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         key_q  <= '0;
         klen_q <= '0;
         kv_q   <= 1'b0;
         kl_q   <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         kv_q <= install;
         if (clr) begin
            key_q  <= '0;
            klen_q <= '0;
            kl_q   <= 1'b0;
            err_q  <= 1'b0;
         end else begin
            if (install) begin
               key_q  <= kmask;
               klen_q <= klen_n;
               kl_q   <= 1'b1;
            end
            if (set_err) err_q <= 1'b1;
         end
      end
   end

   assign head_v = occ != '0;
   assign pop    = head_v && bus.core_ready;
   assign head   = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {cmd_n[0], bsh_n};
   end

   // Clear takes priority over a simultaneous pop.
   always_ff @(posedge clk) begin
      if (reset || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop) occ <= occ + CW'(1);
         else if (pop && !push) occ <= occ - CW'(1);
      end
   end

   assign bus.core_valid = !reset && head_v;
   assign bus.core_blk   = bus.core_valid ? head[127:0] : '0;
   assign bus.core_dec   = bus.core_valid && head[128];
   assign core_key       = reset ? '0 : key_q;
   assign core_key_len   = reset ? '0 : klen_q;
   assign key_valid      = !reset && kv_q;
   assign key_loaded     = !reset && kl_q;
   assign fifo_count     = reset ? '0 : occ;
   assign err_cmd        = !reset && err_q;
endmodule

// File: tb/tb_aes_stream_frontend.sv
// Scoreboard bench for aes_stream_frontend with BUS_W=32, FIFO_DEPTH=4.
module tb_aes_stream_frontend;
  localparam int BUS_W = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [255:0] core_key;
  logic [1:0]   core_key_len;
  logic         key_valid;
  logic         key_loaded;
  logic [2:0]   fifo_count;
  logic         err_cmd;

  int checks = 0;
  int errors = 0;
  logic [128:0] sb[$];
  logic [255:0] cur_key;

  aes_stream_frontend_if #(.BUS_W(BUS_W)) bus ();

  aes_stream_frontend #(
    .BUS_W(BUS_W),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .core_key(core_key),
    .core_key_len(core_key_len),
    .key_valid(key_valid),
    .key_loaded(key_loaded),
    .fifo_count(fifo_count),
    .err_cmd(err_cmd)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  always @(negedge clk) begin
    logic [128:0] exp;
    #1;
    if (!reset && bus.core_valid && bus.core_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL pop_extra got %h", bus.core_blk);
      end else begin
        exp = sb.pop_front();
        if ({bus.core_dec, bus.core_blk} !== exp) begin
          errors++;
          $display("FAIL pop got %h want %h",
                   {bus.core_dec, bus.core_blk}, exp);
        end
      end
    end
  end

  task automatic send(input logic [1:0] c, input logic [31:0] d,
                      input logic [1:0] kl);
    int n = 0;
    bus.in_cmd = c;
    bus.in_data = d;
    bus.key_len = kl;
    bus.in_valid = 1'b1;
    #1;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.in_ready) begin
      checks++;
      errors++;
      $display("FAIL send_timeout cmd %0d ready 0 want 1", c);
    end
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    bus.core_ready = 1'b1;
    while (bus.core_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.core_valid) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout valid 1 want 0");
    end
    bus.core_ready = 1'b0;
  endtask

  task automatic push_block(input logic dec, input logic [127:0] b,
                            input bit track);
    for (int i = 0; i < 4; i++) send({1'b0, dec}, b[32*i +: 32], 2'b00);
    if (track) sb.push_back({dec, b});
  endtask

  task automatic load_key(input logic [255:0] k, input logic [1:0] kl);
    int nb;
    nb = (kl == 2'b00) ? 4 : (kl == 2'b01) ? 6 : 8;
    for (int i = 0; i < nb; i++) send(2'b10, k[32*i +: 32], kl);
    cur_key = k;
    if (kl == 2'b00) cur_key[255:128] = '0;
    if (kl == 2'b01) cur_key[255:192] = '0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic test_reset();
    bus.in_valid = 1'b0;
    bus.in_cmd = 2'b00;
    bus.in_data = '0;
    bus.key_len = 2'b00;
    bus.core_ready = 1'b0;
    reset = 1'b1;
    cur_key = '0;
    repeat (2) @(negedge clk);
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if ({bus.in_ready, bus.core_valid, bus.core_dec, key_valid,
         key_loaded, err_cmd, fifo_count, core_key_len} !== '0) begin
      errors++;
      $display("FAIL reset_ctl got %b want 0",
               {bus.in_ready, bus.core_valid, bus.core_dec, key_valid,
                key_loaded, err_cmd, fifo_count, core_key_len});
    end
    checks++;
    if (core_key !== '0 || bus.core_blk !== '0) begin
      errors++;
      $display("FAIL reset_data key %h blk %h want 0",
               core_key, bus.core_blk);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if ({key_loaded, err_cmd, fifo_count, bus.core_valid} !== '0) begin
      errors++;
      $display("FAIL post_reset got %b want 0",
               {key_loaded, err_cmd, fifo_count, bus.core_valid});
    end
  endtask

  task automatic test_no_key();
    send(2'b00, 32'hdeadbeef, 2'b00);
    checks++;
    if (err_cmd !== 1'b1 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL no_key err %b cnt %0d want 1 0", err_cmd, fifo_count);
    end
    send(2'b11, 32'h0, 2'b00);
    checks++;
    if (err_cmd !== 1'b0) begin
      errors++;
      $display("FAIL no_key_clear err %b want 0", err_cmd);
    end
  endtask

  task automatic test_key256();
    logic [255:0] k;
    for (int b = 0; b < 32; b++) k[8*b +: 8] = 8'(b);
    for (int i = 0; i < 8; i++) begin
      send(2'b10, k[32*i +: 32], 2'b10);
      if (i == 6) begin
        checks++;
        if (core_key !== '0 || key_loaded !== 1'b0) begin
          errors++;
          $display("FAIL key_shadow key %h loaded %b want 0 0",
                   core_key, key_loaded);
        end
      end
    end
    checks++;
    if (key_valid !== 1'b1 || key_loaded !== 1'b1 ||
        core_key_len !== 2'b10) begin
      errors++;
      $display("FAIL key256_flags kv %b kl %b len %b want 1 1 10",
               key_valid, key_loaded, core_key_len);
    end
    checks++;
    if (core_key !== k) begin
      errors++;
      $display("FAIL key256 got %h want %h", core_key, k);
    end
    cur_key = k;
    @(negedge clk);
    checks++;
    if (key_valid !== 1'b0) begin
      errors++;
      $display("FAIL key_valid_pulse got 1 want 0");
    end
  endtask

  task automatic test_encrypt();
    logic [127:0] b;
    b = 128'h00112233445566778899aabbccddeeff;
    for (int i = 0; i < 3; i++) send(2'b00, b[32*i +: 32], 2'b00);
    checks++;
    if (bus.core_valid !== 1'b0) begin
      errors++;
      $display("FAIL enc_early valid 1 want 0");
    end
    send(2'b00, b[127:96], 2'b00);
    sb.push_back({1'b0, b});
    checks++;
    if (bus.core_valid !== 1'b1 || bus.core_blk !== b ||
        bus.core_dec !== 1'b0 || fifo_count !== 3'd1) begin
      errors++;
      $display("FAIL enc v %b blk %h dec %b cnt %0d want 1 %h 0 1",
               bus.core_valid, bus.core_blk, bus.core_dec, fifo_count, b);
    end
    drain();
  endtask

  task automatic test_fifo_full();
    for (int i = 0; i < DEPTH; i++) push_block(1'b1, rnd128(), 1'b1);
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_cnt got %0d want 4", fifo_count);
    end
    bus.in_cmd = 2'b01;
    bus.in_data = 32'h1;
    bus.in_valid = 1'b1;
    #1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_ready got 1 want 0");
    end
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd4) begin
      errors++;
      $display("FAIL full_hold got %0d want 4", fifo_count);
    end
    bus.in_valid = 1'b0;
    drain();
    push_block(1'b1, rnd128(), 1'b1);
    drain();
  endtask

  task automatic test_key_stall();
    logic [127:0] nk;
    nk = rnd128();
    push_block(1'b0, rnd128(), 1'b1);
    push_block(1'b0, rnd128(), 1'b1);
    checks++;
    if (fifo_count !== 3'd2) begin
      errors++;
      $display("FAIL stall_cnt got %0d want 2", fifo_count);
    end
    bus.in_cmd = 2'b10;
    bus.key_len = 2'b00;
    bus.in_data = nk[31:0];
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.in_ready !== 1'b0 || core_key !== cur_key) begin
        errors++;
        $display("FAIL stall rdy %b key %h want 0 %h",
                 bus.in_ready, core_key, cur_key);
      end
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    drain();
    load_key({128'd0, nk}, 2'b00);
    checks++;
    if (core_key !== cur_key || core_key_len !== 2'b00) begin
      errors++;
      $display("FAIL stall_key got %h len %b want %h 00",
               core_key, core_key_len, cur_key);
    end
  endtask

  task automatic test_proto_err();
    logic [127:0] nk;
    logic [255:0] old;
    nk = rnd128();
    old = cur_key;
    send(2'b00, 32'h11, 2'b00);
    send(2'b00, 32'h22, 2'b00);
    send(2'b10, nk[31:0], 2'b00);
    checks++;
    if (err_cmd !== 1'b1 || fifo_count !== 3'd0 || core_key !== old) begin
      errors++;
      $display("FAIL mix err %b cnt %0d key %h want 1 0 %h",
               err_cmd, fifo_count, core_key, old);
    end
    for (int i = 1; i < 4; i++) send(2'b10, nk[32*i +: 32], 2'b00);
    checks++;
    if (core_key !== {128'd0, nk} || key_valid !== 1'b1) begin
      errors++;
      $display("FAIL mix_key got %h kv %b want %h 1",
               core_key, key_valid, {128'd0, nk});
    end
    cur_key = {128'd0, nk};
  endtask

  task automatic test_illegal_len();
    logic [127:0] nk;
    nk = rnd128();
    send(2'b11, 32'h0, 2'b00);
    checks++;
    if (err_cmd !== 1'b0 || key_loaded !== 1'b0 || core_key !== '0) begin
      errors++;
      $display("FAIL clr_key err %b kl %b key %h want 0 0 0",
               err_cmd, key_loaded, core_key);
    end
    send(2'b10, 32'h55, 2'b11);
    checks++;
    if (err_cmd !== 1'b1 || key_loaded !== 1'b0 || key_valid !== 1'b0) begin
      errors++;
      $display("FAIL bad_len err %b kl %b kv %b want 1 0 0",
               err_cmd, key_loaded, key_valid);
    end
    load_key({128'd0, nk}, 2'b00);
    checks++;
    if (core_key !== cur_key || key_loaded !== 1'b1) begin
      errors++;
      $display("FAIL after_bad got %h kl %b want %h 1",
               core_key, key_loaded, cur_key);
    end
  endtask

  task automatic test_clear_reset();
    logic [255:0] k;
    for (int i = 0; i < 3; i++) push_block(1'b0, rnd128(), 1'b0);
    checks++;
    if (fifo_count !== 3'd3) begin
      errors++;
      $display("FAIL clr_pre got %0d want 3", fifo_count);
    end
    send(2'b11, 32'h0, 2'b00);
    checks++;
    if ({fifo_count, key_loaded, err_cmd, bus.core_valid} !== '0 ||
        core_key !== '0) begin
      errors++;
      $display("FAIL clear cnt %0d kl %b err %b v %b key %h want 0",
               fifo_count, key_loaded, err_cmd, bus.core_valid, core_key);
    end
    load_key({128'd0, rnd128()}, 2'b00);
    k = {rnd128(), rnd128()};
    for (int i = 0; i < 3; i++) send(2'b10, k[32*i +: 32], 2'b10);
    reset = 1'b1;
    bus.in_cmd = 2'b10;
    bus.in_valid = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if ({bus.in_ready, bus.core_valid, key_valid, key_loaded, err_cmd,
         fifo_count, core_key_len} !== '0 || core_key !== '0) begin
      errors++;
      $display("FAIL mid_reset rdy %b kl %b key %h want 0",
               bus.in_ready, key_loaded, core_key);
    end
    bus.in_valid = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (key_loaded !== 1'b0 || core_key !== '0 || fifo_count !== 3'd0) begin
      errors++;
      $display("FAIL post_mid kl %b key %h cnt %0d want 0",
               key_loaded, core_key, fifo_count);
    end
  endtask

  initial begin
    test_reset();
    test_no_key();
    test_key256();
    test_encrypt();
    test_fifo_full();
    test_key_stall();
    test_proto_err();
    test_illegal_len();
    test_clear_reset();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_left got %0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/aes_stream_frontend.md
Name: aes_stream_frontend

Overview:
- Parametrised input front end for the AES device; successor to the fixed 128-bit `ctrl_dataIn`/`mod_en` input path.
- Accepts narrow bus beats with a valid/ready handshake and assembles them into 128-bit blocks and 128/192/256-bit keys.
- Buffers assembled blocks, each tagged enc/dec, in a FIFO, and presents them to the AES core over a valid/ready interface.
- Key changes are serialised against in-flight blocks.

Parameters:
- BUS_W, 32, input beat width; legal values 32, 64, 128.
- FIFO_DEPTH, 4, block FIFO entries; power of two, minimum 2.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- in_data  in  BUS_W  input beat.
- in_cmd  in  2  beat type: 00 encrypt data, 01 decrypt data, 10 key, 11 clear (flush FIFO, drop key).
- key_len  in  2  key length: 00=128, 01=192, 10=256, 11 illegal; sampled on the first key beat.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready at the clk edge.
- core_blk  out  128  FIFO head block.
- core_dec  out  1  head tag: 1 = decrypt.
- core_valid  out  1  FIFO not empty.
- core_ready  in  1  core pops the head.
- core_key  out  256  active key, unused upper bits zero.
- core_key_len  out  2  active key length.
- key_valid  out  1  one-cycle pulse when a new key is installed.
- key_loaded  out  1  a valid key is installed.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  occupancy.
- err_cmd  out  1  sticky protocol error; cleared by reset or a clear command.

Behaviour:
- **Reset:** while reset is high, every output is 0, including in_ready and core_key. The FIFO is emptied and the FSM goes to IDLE.
- **Beat packing:** the first beat fills bits [BUS_W-1:0]; each later beat fills the next BUS_W slice upward.
- **Beat counts:**
  - Blocks take 128/BUS_W beats.
  - Keys take ceil(keybits/BUS_W) beats. Bits beyond keybits in the last beat are ignored.
- **FSM states:**
  - IDLE → ASM_BLK on an accepted data beat.
  - IDLE → ASM_KEY on an accepted key beat.
  - ASM_BLK → IDLE after the final beat, which pushes the block.
  - ASM_KEY → IDLE after the final beat, which installs the key.
- **Key install:**
  - Keys assemble in a shadow register; core_key/core_key_len stay unchanged until the last key beat.
  - Last key beat accepted at edge N: core_key, core_key_len, key_loaded=1 and key_valid=1 all appear after edge N. key_valid drops after edge N+1.
- **Block latency:** final block beat accepted at edge N → entry visible at the FIFO head, core_valid=1, after edge N if the FIFO was empty.
- **FIFO pop:** on core_valid && core_ready. A push and pop in the same edge leaves fifo_count unchanged.
- **in_ready:** may depend combinationally on in_cmd. It is high unless any of the following holds:
  - reset is high;
  - a data beat arrives with fifo_count == FIFO_DEPTH;
  - a key beat arrives in IDLE with fifo_count != 0 (key stalls until the FIFO drains);
  - key_valid is high.
- **Data with no key:** a data beat with key_loaded=0 is accepted and dropped, and err_cmd is set.
- **in_cmd change mid-assembly:** the partial block/key is discarded and err_cmd is set. The offending beat starts a fresh assembly of its own type.
- **Illegal key_len=11:** on the first key beat, the beat is dropped, err_cmd is set, and the FSM stays in IDLE.
- **Clear (cmd 11):** single-beat, always accepted. Next edge:
  - FIFO emptied;
  - key_loaded=0 and core_key=0;
  - partial assembly discarded;
  - err_cmd=0;
  - FSM → IDLE.
  - Clear and a pop in the same edge: the clear wins.
- **Reset mid-operation:** the partial assembly and FIFO contents are lost; no key survives.
- **Counters:** the beat counter wraps to 0 after each completed block or key. fifo_count never exceeds FIFO_DEPTH or goes below 0.

Test Plan:
- **AES-256 key load:** BUS_W=32, key_len=10, 8 key beats 0x03020100…0x1f1e1d1c → core_key=0x1f1e…0100; key_valid high exactly 1 cycle; key_loaded=1.
- **Encrypt block:** 4 cmd=00 beats 0xccddeeff,0x8899aabb,0x44556677,0x00112233 → core_blk=0x00112233445566778899aabbccddeeff; core_dec=0; core_valid 1 cycle after the last beat.
- **FIFO full:** core_ready=0, push 5 decrypt blocks with FIFO_DEPTH=4 → fifo_count=4; in_ready=0 on the 17th beat. Then core_ready=1 → blocks pop in order, each with core_dec=1.
- **Key stall:** key beat while fifo_count=2 → in_ready=0 until the FIFO empties. The old core_key is held during the drain; the new key installs afterwards.
- **Protocol errors:** data beat with no key → err_cmd=1, fifo_count=0. Key beat inserted after 2 data beats → partial block discarded, err_cmd=1, key assembly starts.
- **Clear and reset:** clear beat with 3 blocks queued → fifo_count=0, key_loaded=0, err_cmd=0 next cycle. Reset mid-key-assembly → all outputs 0.
